// File: rtl/axi_ram_responder.sv
// AXI3 slave that terminates DMA burst traffic into a dual-port on-chip RAM.
// Optional address range checking is enabled by defining AXI_RAM_RESPONDER_RANGE_CHECK_EN.
module axi_ram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int AXI_ID_WIDTH = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h1E000000
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [3:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_wid,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [3:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        wlast_err,
    output logic [1:0]                  w_state_dbg,
    output logic                        r_state_dbg
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFFB   = $clog2(STRB_W);
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_BURST} r_state_t;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize, s_axi_awburst, s_axi_wid, s_axi_arsize, s_axi_arburst};

    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return ADDR_WIDTH'((addr - BASE_ADDR) >> OFFB);
    endfunction

    logic aw_oob, ar_oob;
`ifdef AXI_RAM_RESPONDER_RANGE_CHECK_EN
    localparam logic [AXI_ADDR_WIDTH:0] DEPTH_W = (AXI_ADDR_WIDTH+1)'(DEPTH);

    // Checked in word units: a beat is in range iff its word index is below the RAM depth.
    function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] addr, input logic [3:0] len);
        logic [AXI_ADDR_WIDTH:0] first_word, last_word;
        first_word = {1'b0, (addr - BASE_ADDR) >> OFFB};
        last_word  = first_word + {{(AXI_ADDR_WIDTH-3){1'b0}}, len};
        return (first_word >= DEPTH_W) || (last_word >= DEPTH_W);
    endfunction

    assign aw_oob = out_of_range(s_axi_awaddr, s_axi_awlen);
    assign ar_oob = out_of_range(s_axi_araddr, s_axi_arlen);
`else
    assign aw_oob = 1'b0;
    assign ar_oob = 1'b0;
`endif

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    w_state_t                w_state, w_state_next;
    logic [AXI_ID_WIDTH-1:0] w_id;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [3:0]              w_cnt;
    logic                    w_err;
    logic                    aw_fire, w_fire;

    always_comb begin
        w_state_next  = w_state;
        s_axi_awready = (w_state == W_IDLE) && !areset;
        s_axi_wready  = (w_state == W_DATA) && !areset;
        s_axi_bvalid  = (w_state == W_RESP);
        s_axi_bresp   = (s_axi_bvalid && w_err) ? 2'b10 : 2'b00;
        aw_fire       = s_axi_awvalid && s_axi_awready;
        w_fire        = s_axi_wvalid && s_axi_wready;
        case (w_state)
            W_IDLE:  if (aw_fire) w_state_next = W_DATA;
            W_DATA:  if (w_fire && w_cnt == 4'd0) w_state_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state   <= W_IDLE;
            w_id      <= '0;
            w_idx     <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            wlast_err <= 1'b0;
        end else begin
            w_state <= w_state_next;
            if (aw_fire) begin
                w_id  <= s_axi_awid;
                w_idx <= word_index(s_axi_awaddr);
                w_cnt <= s_axi_awlen;
                w_err <= aw_oob;
            end
            if (w_fire) begin
                w_idx <= w_idx + 1'b1;
                w_cnt <= w_cnt - 4'd1;
                if (s_axi_wlast != (w_cnt == 4'd0)) wlast_err <= 1'b1;
            end
        end
    end

    assign s_axi_bid   = w_id;
    assign w_state_dbg = w_state;

    always_ff @(posedge aclk) begin
        if (w_fire && !w_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // Read path: RAM issue -> one-cycle read register -> 2-entry FIFO that drives R.
    r_state_t                  r_state, r_state_next;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0]     r_idx;
    logic [4:0]                r_left;
    logic                      r_err;
    logic                      rd_issue, rd_pend, rd_pend_last, ar_fire, r_fire;
    logic [AXI_DATA_WIDTH-1:0] rd_data;
    logic [AXI_DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]                fifo_last;
    logic                      fifo_wptr, fifo_rptr;
    logic [1:0]                fifo_cnt;

    always_comb begin
        r_state_next  = r_state;
        s_axi_arready = (r_state == R_IDLE) && !areset;
        s_axi_rvalid  = (fifo_cnt != 2'd0);
        s_axi_rdata   = fifo_data[fifo_rptr];
        s_axi_rlast   = s_axi_rvalid && fifo_last[fifo_rptr];
        s_axi_rresp   = (s_axi_rvalid && r_err) ? 2'b10 : 2'b00;
        ar_fire       = s_axi_arvalid && s_axi_arready;
        r_fire        = s_axi_rvalid && s_axi_rready;
        // Only issue when the beat already in flight plus this one still fit after any pop.
        rd_issue      = (r_state == R_BURST) && (r_left != 5'd0) &&
                        ((3'(fifo_cnt) + 3'(rd_pend)) < (3'd2 + 3'(r_fire)));
        case (r_state)
            R_IDLE:  if (ar_fire) r_state_next = R_BURST;
            R_BURST: if (r_fire && fifo_last[fifo_rptr]) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= R_IDLE;
            r_id         <= '0;
            r_idx        <= '0;
            r_left       <= '0;
            r_err        <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            fifo_wptr    <= 1'b0;
            fifo_rptr    <= 1'b0;
            fifo_cnt     <= '0;
        end else begin
            r_state <= r_state_next;
            if (ar_fire) begin
                r_id   <= s_axi_arid;
                r_idx  <= word_index(s_axi_araddr);
                r_left <= {1'b0, s_axi_arlen} + 5'd1;
                r_err  <= ar_oob;
            end
            if (rd_issue) begin
                r_idx  <= r_idx + 1'b1;
                r_left <= r_left - 5'd1;
            end
            rd_pend      <= rd_issue;
            rd_pend_last <= rd_issue && (r_left == 5'd1);
            if (rd_pend) begin
                fifo_data[fifo_wptr] <= r_err ? '0 : rd_data;
                fifo_last[fifo_wptr] <= rd_pend_last;
                fifo_wptr            <= ~fifo_wptr;
            end
            if (r_fire) fifo_rptr <= ~fifo_rptr;
            fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, r_fire};
        end
    end

    // Separate port from the write side; same-word collisions return the old contents.
    always_ff @(posedge aclk) begin
        if (rd_issue) rd_data <= mem[r_idx];
    end

    assign s_axi_rid   = r_id;
    assign r_state_dbg = r_state;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder: vector table of single-beat write/read pairs
// plus hand-written burst, backpressure, collision, wlast and reset sequences.
module tb_axi_ram_responder;
    localparam logic [31:0] BASE = 32'h1E000000;

    logic        aclk = 1'b0;
    logic        areset;
    logic [5:0]  s_axi_awid, s_axi_wid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [31:0] s_axi_awaddr, s_axi_araddr;
    logic [3:0]  s_axi_awlen, s_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize;
    logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready, wlast_err, r_state_dbg;
    logic [63:0] s_axi_wdata, s_axi_rdata;
    logic [7:0]  s_axi_wstrb;
    logic [1:0]  w_state_dbg;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [5:0]  id;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[8];

    always #5 aclk = ~aclk;

    axi_ram_responder dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wlast_err(wlast_err), .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
        int n = 0;
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = id; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
        check("aw_accept", s_axi_awready, 1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
        int n = 0;
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
        check("ar_accept", s_axi_arready, 1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic w_burst(input int beats, input int last_at, input logic [63:0] first, input logic [7:0] strb);
        for (int i = 0; i < beats; i++) begin
            int n = 0;
            s_axi_wdata = first + 64'(i); s_axi_wstrb = strb;
            s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
            while (!s_axi_wready && n < 50) begin @(negedge aclk); n++; end
            check("w_accept", s_axi_wready, 1);
            check("no_early_b", s_axi_bvalid, 0);
            @(posedge aclk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic b_wait(input logic [5:0] id, input logic [1:0] resp);
        int n = 0;
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && n < 50) begin @(negedge aclk); n++; end
        check("b_valid", s_axi_bvalid, 1);
        check("bid", s_axi_bid, id);
        check("bresp", s_axi_bresp, resp);
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    // Pops one expected word from exp_q per accepted beat; also checks R stays put while stalled.
    task automatic r_collect(input int beats, input bit toggle, input logic [5:0] id,
                             input logic [1:0] resp, output int cycles);
        int n = 0;
        int got = 0;
        logic held = 1'b0;
        logic [63:0] held_data = '0;
        while (got < beats && n < 500) begin
            s_axi_rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            if (held) begin
                check("rvalid_held", s_axi_rvalid, 1);
                check("rdata_held", s_axi_rdata, held_data);
            end
            held = s_axi_rvalid && !s_axi_rready;
            held_data = s_axi_rdata;
            if (s_axi_rvalid && s_axi_rready) begin
                got++;
                check("r_exp_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("rdata", s_axi_rdata, exp_q.pop_front());
                check("rlast", s_axi_rlast, got == beats);
                check("rid", s_axi_rid, id);
                check("rresp", s_axi_rresp, resp);
            end
            @(posedge aclk); #1;
            n++;
        end
        s_axi_rready = 1'b0;
        cycles = n;
        check("r_beat_count", got, beats);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        vecs[0] = '{BASE + 32'h200, 64'h0123_4567_89AB_CDEF, 8'hFF, 6'h01, 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{BASE + 32'h200, 64'h0000_0000_0000_0000, 8'h01, 6'h02, 64'h0123_4567_89AB_CD00};
        vecs[2] = '{BASE + 32'h205, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 6'h03, 64'hFF23_4567_89AB_CD00};
        vecs[3] = '{BASE + 32'h1FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 6'h04, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[4] = '{BASE + 32'hA0, 64'h0000_0000_0000_0000, 8'hFF, 6'h05, 64'h0000_0000_0000_0000};
        vecs[5] = '{BASE + 32'hA0, 64'h5555_AAAA_5555_AAAA, 8'h3C, 6'h06, 64'h0000_AAAA_5555_0000};
        vecs[6] = '{BASE + 32'hA8, 64'h1111_2222_3333_4444, 8'hFF, 6'h07, 64'h1111_2222_3333_4444};
        vecs[7] = '{BASE + 32'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 6'h08, 64'hFF23_4567_89AB_CD00};

        areset = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0; s_axi_wid = '0; s_axi_wdata = '0;
        s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", s_axi_awready, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_wlast_err", wlast_err, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_rlast", s_axi_rlast, 0);
        check("rst_ids", {s_axi_bid, s_axi_rid}, 0);
        check("rst_resps", {s_axi_bresp, s_axi_rresp}, 0);
        check("rst_states", {w_state_dbg, r_state_dbg}, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("awready_after_rst", s_axi_awready, 1);
        check("arready_after_rst", s_axi_arready, 1);
        @(posedge aclk); #1;

        // 16-beat write then 16-beat read at BASE
        aw_send(BASE, 4'd15, 6'h2A);
        w_burst(16, 15, 64'd0, 8'hFF);
        check("b_one_cycle_after_last", s_axi_bvalid, 1);
        b_wait(6'h2A, 2'b00);
        for (int i = 0; i < 16; i++) exp_q.push_back(64'(i));
        ar_send(BASE, 4'd15, 6'h15);
        @(negedge aclk); check("rvalid_lat1", s_axi_rvalid, 0);
        @(negedge aclk); check("rvalid_lat2", s_axi_rvalid, 0);
        @(negedge aclk); check("rvalid_lat3", s_axi_rvalid, 1);
        @(posedge aclk); #1;
        r_collect(16, 1'b0, 6'h15, 2'b00, cyc);
        check("r_full_rate_cycles", cyc, 16);
        check("arready_after_burst", s_axi_arready, 1);

        // 8-beat read under random backpressure
        for (int i = 0; i < 8; i++) exp_q.push_back(64'(i));
        ar_send(BASE, 4'd7, 6'h09);
        r_collect(8, 1'b1, 6'h09, 2'b00, cyc);

        // Byte strobes on word 3
        aw_send(BASE + 32'h18, 4'd0, 6'h11);
        w_burst(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        b_wait(6'h11, 2'b00);
        aw_send(BASE + 32'h18, 4'd0, 6'h12);
        w_burst(1, 0, 64'h0, 8'h0F);
        b_wait(6'h12, 2'b00);
        exp_q.push_back(64'hFFFF_FFFF_0000_0000);
        ar_send(BASE + 32'h18, 4'd0, 6'h13);
        r_collect(1, 1'b0, 6'h13, 2'b00, cyc);

        // Same-cycle write and read of word 5 returns the old value
        aw_send(BASE + 32'h28, 4'd0, 6'h21);
        w_burst(1, 0, 64'hA, 8'hFF);
        b_wait(6'h21, 2'b00);
        aw_send(BASE + 32'h28, 4'd0, 6'h22);
        ar_send(BASE + 32'h28, 4'd0, 6'h23);
        s_axi_wdata = 64'hB; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge aclk);
        check("collide_wready", s_axi_wready, 1);
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        b_wait(6'h22, 2'b00);
        exp_q.push_back(64'hA);
        r_collect(1, 1'b0, 6'h23, 2'b00, cyc);
        exp_q.push_back(64'hB);
        ar_send(BASE + 32'h28, 4'd0, 6'h24);
        r_collect(1, 1'b0, 6'h24, 2'b00, cyc);

        // Early wlast: count still defines the burst, error is sticky
        check("wlast_err_clean", wlast_err, 0);
        aw_send(BASE + 32'h300, 4'd3, 6'h31);
        w_burst(4, 1, 64'h300, 8'hFF);
        check("wlast_err_set", wlast_err, 1);
        b_wait(6'h31, 2'b00);
        repeat (3) begin
            @(negedge aclk);
            check("single_b", s_axi_bvalid, 0);
        end
        @(posedge aclk); #1;
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h300 + 64'(i));
        ar_send(BASE + 32'h300, 4'd3, 6'h32);
        r_collect(4, 1'b0, 6'h32, 2'b00, cyc);
        check("wlast_err_sticky", wlast_err, 1);

        // Vector table: single-beat write then read-back
        for (int v = 0; v < 8; v++) begin
            aw_send(vecs[v].addr, 4'd0, vecs[v].id);
            w_burst(1, 0, vecs[v].data, vecs[v].strb);
            b_wait(vecs[v].id, 2'b00);
            exp_q.push_back(vecs[v].exp);
            ar_send(vecs[v].addr, 4'd0, vecs[v].id ^ 6'h3F);
            r_collect(1, 1'b0, vecs[v].id ^ 6'h3F, 2'b00, cyc);
        end

`ifdef AXI_RAM_RESPONDER_RANGE_CHECK_EN
        // Out-of-range read and write
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        ar_send(BASE - 32'h8, 4'd1, 6'h3A);
        r_collect(2, 1'b0, 6'h3A, 2'b10, cyc);
        aw_send(BASE + 32'h1FF8, 4'd1, 6'h3B);
        w_burst(2, 1, 64'h7700, 8'hFF);
        b_wait(6'h3B, 2'b10);
        exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
        ar_send(BASE + 32'h1FF8, 4'd0, 6'h3C);
        r_collect(1, 1'b0, 6'h3C, 2'b00, cyc);
`else
        // Index wraps at the top of the RAM
        aw_send(BASE + 32'h1FF8, 4'd1, 6'h3B);
        w_burst(2, 1, 64'h7700, 8'hFF);
        b_wait(6'h3B, 2'b00);
        exp_q.push_back(64'h7701);
        ar_send(BASE, 4'd0, 6'h3C);
        r_collect(1, 1'b0, 6'h3C, 2'b00, cyc);
        exp_q.push_back(64'h7700);
        exp_q.push_back(64'h7701);
        ar_send(BASE + 32'h1FF8, 4'd1, 6'h3D);
        r_collect(2, 1'b0, 6'h3D, 2'b00, cyc);
`endif

        // Reset in the middle of a write burst
        aw_send(BASE + 32'h400, 4'd7, 6'h05);
        w_burst(2, 99, 64'h400, 8'hFF);
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("mid_rst_awready", s_axi_awready, 1);
        check("mid_rst_bvalid", s_axi_bvalid, 0);
        check("mid_rst_wready", s_axi_wready, 0);
        check("mid_rst_wlast_err", wlast_err, 0);
        repeat (3) begin
            @(negedge aclk);
            check("mid_rst_no_b", s_axi_bvalid, 0);
        end
        @(posedge aclk); #1;
        aw_send(BASE + 32'h400, 4'd0, 6'h06);
        w_burst(1, 0, 64'h4242, 8'hFF);
        b_wait(6'h06, 2'b00);
        exp_q.push_back(64'h4242);
        ar_send(BASE + 32'h400, 4'd0, 6'h07);
        r_collect(1, 1'b0, 6'h07, 2'b00, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
